// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: RV32 data memory behind a ready/valid request/response
// handshake with a configurable number of wait states between accept and
// commit. Supports LB/LH/LW/LBU/LHU and SB/SH/SW with byte lanes and
// sign/zero extension.
//
// Optional build macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses return resp_err=1, no write.
//   undefined -> misaligned low address bits are masked, access proceeds.
module dmem_wait_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS * 4),
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Access legality: illegal funct3, store-with-unsigned, or (optionally) misalignment.
  function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                      input logic mis_half, input logic mis_word);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = mis_half;
      3'b010:  bad = mis_word;
      3'b100:  bad = we;
      3'b101:  bad = we | mis_half;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-enable mask for a store of the given size at the given low address bits.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (f3[1:0])
      2'b00: begin
        case (lo)
          2'd0:    be = 4'b0001;
          2'd1:    be = 4'b0010;
          2'd2:    be = 4'b0100;
          2'd3:    be = 4'b1000;
          default: be = 4'b0000;
        endcase
      end
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across all lanes it could land in.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    w = wd;
    case (f3[1:0])
      2'b00:   w = {4{wd[7:0]}};
      2'b01:   w = {2{wd[15:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    r = 32'h0000_0000;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h00_0000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;
  logic                we_r;
  logic [2:0]          funct3_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic                latch_s;
  logic                commit_s;
  logic                err_now_s;
  logic                bad_s;
  logic                mis_half_s;
  logic                mis_word_s;

  logic                c_we_s;
  logic [2:0]          c_funct3_s;
  logic [ADDR_W-1:0]   c_addr_s;
  logic [31:0]         c_wdata_s;
  logic [IDX_W-1:0]    c_idx_s;
  logic [3:0]          c_be_s;
  logic [31:0]         c_wlanes_s;
  logic [31:0]         c_rword_s;
  logic [31:0]         c_rext_s;
  logic                wr_en_s;

  logic                req_ready_r;
  logic                resp_valid_r;
  logic [31:0]         resp_rdata_r;
  logic                resp_err_r;

  logic [31:0]         mem_r [DEPTH_WORDS];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_half_s = req_addr[0];
  assign mis_word_s = |req_addr[1:0];
`else
  assign mis_half_s = 1'b0;
  assign mis_word_s = 1'b0;
`endif

  assign bad_s = access_bad(req_we, req_funct3, mis_half_s, mis_word_s);

  // Commit uses the live request when committing on the accept edge, else the latched one.
  always_comb begin
    c_we_s     = we_r;
    c_funct3_s = funct3_r;
    c_addr_s   = addr_r;
    c_wdata_s  = wdata_r;
    if (state_r == ST_IDLE) begin
      c_we_s     = req_we;
      c_funct3_s = req_funct3;
      c_addr_s   = req_addr;
      c_wdata_s  = req_wdata;
    end else begin
      c_we_s     = we_r;
      c_funct3_s = funct3_r;
      c_addr_s   = addr_r;
      c_wdata_s  = wdata_r;
    end
  end

  assign c_idx_s    = c_addr_s[ADDR_W-1:2];
  assign c_be_s     = byte_en(c_funct3_s, c_addr_s[1:0]);
  assign c_wlanes_s = store_lanes(c_funct3_s, c_wdata_s);
  assign c_rword_s  = mem_r[c_idx_s];
  assign c_rext_s   = load_ext(c_funct3_s, c_addr_s[1:0], c_rword_s);
  assign wr_en_s    = commit_s & c_we_s & reset_n;

  // Next-state logic for the IDLE -> WAIT -> RESP handshake sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    commit_s    = 1'b0;
    err_now_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          latch_s = 1'b1;
          if (bad_s) begin
            err_now_s   = 1'b1;
            state_nxt_s = ST_RESP;
          end else if (WAIT_STATES == 0) begin
            commit_s    = 1'b1;
            state_nxt_s = ST_RESP;
          end else begin
            cnt_nxt_s   = 4'(WAIT_STATES - 1);
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          commit_s    = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and request latch; reset drops any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      we_r     <= 1'b0;
      funct3_r <= 3'b000;
      addr_r   <= '0;
      wdata_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (latch_s) begin
        we_r     <= req_we;
        funct3_r <= req_funct3;
        addr_r   <= req_addr;
        wdata_r  <= req_wdata;
      end
    end
  end

  // Registered handshake outputs; response data is captured only on entry to RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      if ((state_nxt_s == ST_RESP) && (state_r != ST_RESP)) begin
        resp_valid_r <= 1'b1;
        resp_err_r   <= err_now_s;
        resp_rdata_r <= (commit_s && !c_we_s) ? c_rext_s : 32'h0000_0000;
      end else if ((state_r == ST_RESP) && resp_ready) begin
        resp_valid_r <= 1'b0;
      end
    end
  end

  // Byte-lane write into the data array at the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be_s[i]) begin
          mem_r[c_idx_s][8*i +: 8] <= c_wlanes_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed self-checking bench for dmem_wait_ctrl: one instance with two wait
// states and one with zero wait states. Expected values are hand-computed.
module tb_dmem_wait_ctrl;

  localparam int AW = 10;

  logic          clk;
  logic          reset_n;
  logic          req_valid2, req_valid0;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_ready;

  logic          req_ready2, resp_valid2, resp_err2;
  logic [31:0]   resp_rdata2;
  logic          req_ready0, resp_valid0, resp_err0;
  logic [31:0]   resp_rdata0;

  int n_chk;
  int n_err;

  dmem_wait_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid2), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata2), .resp_err(resp_err2)
  );

  dmem_wait_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request to the selected instance and check latency, data and error.
  task automatic do_req(input logic sel0, input logic we, input logic [2:0] f3,
                        input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input logic hold, input string tag);
    int lat;
    @(negedge clk);
    resp_ready = !hold;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (sel0) req_valid0 = 1'b1;
    else      req_valid2 = 1'b1;
    check({tag, "/ready"}, {31'd0, sel0 ? req_ready0 : req_ready2}, 32'd1);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid2 = 1'b0;
    lat = 1;
    while (((sel0 ? resp_valid0 : resp_valid2) !== 1'b1) && (lat < 20)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "/rdata"}, sel0 ? resp_rdata0 : resp_rdata2, exp_rd);
    check({tag, "/err"}, {31'd0, sel0 ? resp_err0 : resp_err2}, {31'd0, exp_err});
    if (!hold) @(posedge clk);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    req_valid2 = 1'b0;
    req_valid0 = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    #12;
    check("rst/ready",  {31'd0, req_ready2}, 32'd1);
    check("rst/valid",  {31'd0, resp_valid2}, 32'd0);
    check("rst/rdata",  resp_rdata2, 32'h0);
    check("rst/err",    {31'd0, resp_err2}, 32'd0);
    check("rst/valid0", {31'd0, resp_valid0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Word store/load, latency WAIT_STATES+1
    do_req(1'b0, 1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b0, "sw010");
    do_req(1'b0, 1'b0, 3'b010, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0, "lw010a");

    // Byte lane store, signed/unsigned byte loads
    do_req(1'b0, 1'b1, 3'b000, 10'h013, 32'h00000080, 32'h0, 1'b0, 3, 1'b0, "sb013");
    do_req(1'b0, 1'b0, 3'b000, 10'h013, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b0, "lb013");
    do_req(1'b0, 1'b0, 3'b100, 10'h013, 32'h0, 32'h00000080, 1'b0, 3, 1'b0, "lbu013");
    do_req(1'b0, 1'b0, 3'b010, 10'h010, 32'h0, 32'h80ADBEEF, 1'b0, 3, 1'b0, "lw010b");

    // Half store to upper half, unsigned half load, word load
    do_req(1'b0, 1'b1, 3'b001, 10'h012, 32'hFFFF1234, 32'h0, 1'b0, 3, 1'b0, "sh012");
    do_req(1'b0, 1'b0, 3'b101, 10'h012, 32'h0, 32'h00001234, 1'b0, 3, 1'b0, "lhu012");
    do_req(1'b0, 1'b0, 3'b001, 10'h010, 32'h0, 32'hFFFFBEEF, 1'b0, 3, 1'b0, "lh010");

    // Back-pressure: hold resp_ready low, outputs stay, pulsed requests ignored
    do_req(1'b0, 1'b0, 3'b010, 10'h010, 32'h0, 32'h1234BEEF, 1'b0, 3, 1'b1, "lw010c");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 10'h010;
      req_wdata  = 32'h0;
      req_valid2 = (k % 2 == 0);
      @(posedge clk);
      #1;
      check("bp/valid", {31'd0, resp_valid2}, 32'd1);
      check("bp/rdata", resp_rdata2, 32'h1234BEEF);
      check("bp/ready", {31'd0, req_ready2}, 32'd0);
    end
    @(negedge clk);
    req_valid2 = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp/release_valid", {31'd0, resp_valid2}, 32'd0);
    check("bp/release_ready", {31'd0, req_ready2}, 32'd1);
    @(posedge clk);
    #1;
    check("bp/no_accept", {31'd0, resp_valid2}, 32'd0);

    // Misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
    do_req(1'b0, 1'b0, 3'b010, 10'h011, 32'h0, 32'h0, 1'b1, 1, 1'b0, "lw011");
`else
    do_req(1'b0, 1'b0, 3'b010, 10'h011, 32'h0, 32'h1234BEEF, 1'b0, 3, 1'b0, "lw011");
`endif

    // Illegal funct3 on load and store; the word must be unchanged
    do_req(1'b0, 1'b1, 3'b010, 10'h030, 32'h0BADF00D, 32'h0, 1'b0, 3, 1'b0, "sw030pre");
    do_req(1'b0, 1'b1, 3'b010, 10'h020, 32'h11223344, 32'h0, 1'b0, 3, 1'b0, "sw020");
    do_req(1'b0, 1'b0, 3'b011, 10'h020, 32'h0, 32'h0, 1'b1, 1, 1'b0, "ld011");
    do_req(1'b0, 1'b1, 3'b100, 10'h020, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0, "st100");
    do_req(1'b0, 1'b1, 3'b111, 10'h020, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0, "st111");
    do_req(1'b0, 1'b0, 3'b010, 10'h020, 32'h0, 32'h11223344, 1'b0, 3, 1'b0, "lw020");

    // Reset during WAIT drops the pending store
    @(negedge clk);
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 10'h030;
    req_wdata  = 32'hA5A5A5A5;
    req_valid2 = 1'b1;
    @(posedge clk);
    #1;
    req_valid2 = 1'b0;
    check("wr/in_wait", {31'd0, req_ready2}, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("wr/valid", {31'd0, resp_valid2}, 32'd0);
    check("wr/rdata", resp_rdata2, 32'h0);
    check("wr/err",   {31'd0, resp_err2}, 32'd0);
    check("wr/ready", {31'd0, req_ready2}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b0, 1'b0, 3'b010, 10'h030, 32'h0, 32'h0BADF00D, 1'b0, 3, 1'b0, "lw030");

    // Zero wait states: latency 1
    do_req(1'b1, 1'b1, 3'b010, 10'h040, 32'hCAFEF00D, 32'h0, 1'b0, 1, 1'b0, "w0_sw");
    do_req(1'b1, 1'b0, 3'b010, 10'h040, 32'h0, 32'hCAFEF00D, 1'b0, 1, 1'b0, "w0_lw");
    do_req(1'b1, 1'b0, 3'b000, 10'h043, 32'h0, 32'hFFFFFFCA, 1'b0, 1, 1'b0, "w0_lb");
    do_req(1'b1, 1'b0, 3'b110, 10'h040, 32'h0, 32'h0, 1'b1, 1, 1'b0, "w0_bad");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
